// File: rtl/operand_fetch_stage_if.sv
// Decode-side and execute-side handshake bundle for operand_fetch_stage.
// master = the decode/execute environment, slave = the stage itself.
interface operand_fetch_stage_if #(
  parameter int OP_W   = 12,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [3:0]        in_rd;
  logic              in_rd_we;

  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [3:0]        out_rd;
  logic              out_rd_we;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rd_we, out_a, out_b
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_rd_we, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rd_we, out_a, out_b
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Issue / operand-fetch stage: regfile read, RAW/WAW scoreboard, operand hold under backpressure.
// Define OPFETCH_FWD_EN to let a writeback on the accept edge clear hazards and bypass its data.
module operand_fetch_stage #(
  parameter int OP_W   = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_stage_if.slave bus,
  output logic [3:0]        rf_rd_1,
  output logic [3:0]        rf_rd_2,
  input  logic [DATA_W-1:0] rf_rd_1_data,
  input  logic [DATA_W-1:0] rf_rd_2_data,
  input  logic              wb_en,
  input  logic [3:0]        wb_wr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [15:0]       pending
);

`ifdef OPFETCH_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [3:0]        out_rd_q, out_rd_d;
  logic              out_rd_we_q, out_rd_we_d;
  logic              fresh_q, fresh_d;
  logic [3:0]        rs1_q, rs1_d;
  logic [3:0]        rs2_q, rs2_d;
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic [DATA_W-1:0] hold2_q, hold2_d;
  logic [15:0]       pending_q, pending_d;

  logic clr_rs1, clr_rs2, clr_rd;
  logic raw1, raw2, waw, haz, accept;
  logic [DATA_W-1:0] op_a, op_b;

  assign clr_rs1 = FWD_EN && wb_en && (wb_wr == bus.in_rs1);
  assign clr_rs2 = FWD_EN && wb_en && (wb_wr == bus.in_rs2);
  assign clr_rd  = FWD_EN && wb_en && (wb_wr == bus.in_rd);

  assign raw1 = (bus.in_rs1 != 4'd0) && pending_q[bus.in_rs1] && !clr_rs1;
  assign raw2 = (bus.in_rs2 != 4'd0) && pending_q[bus.in_rs2] && !clr_rs2;
  assign waw  = bus.in_rd_we && (bus.in_rd != 4'd0) && pending_q[bus.in_rd] && !clr_rd;
  assign haz  = raw1 || raw2 || waw;

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !haz;
  assign accept       = bus.in_valid && bus.in_ready;

  assign rf_rd_1 = bus.in_rs1;
  assign rf_rd_2 = bus.in_rs2;

  // The regfile data is only meaningful in the first cycle after accept; later it tracks new addresses.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rs1_q != 4'd0) op_a = fresh_q ? (byp1_q ? byp_data_q : rf_rd_1_data) : hold1_q;
    if (rs2_q != 4'd0) op_b = fresh_q ? (byp2_q ? byp_data_q : rf_rd_2_data) : hold2_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    fresh_d     = fresh_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    byp1_d      = byp1_q;
    byp2_d      = byp2_q;
    byp_data_d  = byp_data_q;
    hold1_d     = hold1_q;
    hold2_d     = hold2_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_op_d    = bus.in_op;
      out_rd_d    = bus.in_rd;
      out_rd_we_d = bus.in_rd_we;
      fresh_d     = 1'b1;
      rs1_d       = bus.in_rs1;
      rs2_d       = bus.in_rs2;
      byp1_d      = clr_rs1;
      byp2_d      = clr_rs2;
      byp_data_d  = FWD_EN ? wb_data : '0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && !bus.out_ready && fresh_q) begin
      hold1_d = op_a;
      hold2_d = op_b;
      fresh_d = 1'b0;
    end
  end

  // A set from this edge's accept overrides a clear from this edge's writeback.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_wr] = 1'b0;
    if (accept && bus.in_rd_we && (bus.in_rd != 4'd0)) pending_d[bus.in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      fresh_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      byp_data_q  <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      fresh_q     <= fresh_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      byp_data_q  <= byp_data_d;
      hold1_q     <= hold1_d;
      hold2_q     <= hold2_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_rd_we = out_rd_we_q;
  assign bus.out_a     = op_a;
  assign bus.out_b     = op_b;
  assign pending       = pending_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: registered-read regfile model, vector table and corner-case sequences.
// Build with OPFETCH_FWD_EN defined to exercise the same-edge forwarding variant.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rf_rd_1, rf_rd_2;
  logic [15:0] rf_rd_1_data, rf_rd_2_data;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_wr = '0;
  logic [15:0] wb_data = '0;
  logic [15:0] pending;

  operand_fetch_stage_if #(.OP_W(12), .DATA_W(16)) bus ();

  operand_fetch_stage #(.OP_W(12), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_rd_1(rf_rd_1), .rf_rd_2(rf_rd_2),
    .rf_rd_1_data(rf_rd_1_data), .rf_rd_2_data(rf_rd_2_data),
    .wb_en(wb_en), .wb_wr(wb_wr), .wb_data(wb_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Regfile: reads registered one cycle after the address, so a same-edge write returns stale data.
  logic [15:0] regs [16];
  always @(posedge clk) begin
    rf_rd_1_data <= regs[rf_rd_1];
    rf_rd_2_data <= regs[rf_rd_2];
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h1111 * 16'(i);
      regs[3] <= 16'h1234;
    end else if (wb_en && wb_wr != 4'd0) begin
      regs[wb_wr] <= wb_data;
    end
  end

  typedef struct {
    logic [11:0] op;
    logic [3:0]  rd;
    logic        we;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  typedef struct {
    logic [11:0] op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        we;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  exp_t        sb [$];
  exp_t        mon_e;
  vec_t        vecs [6];
  int          checks = 0;
  int          errors = 0;
  int          handshakes = 0;
  logic [15:0] drv_ea = '0;
  logic [15:0] drv_eb = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [11:0] op, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic [3:0] rd, input logic we,
                               input logic [15:0] ea, input logic [15:0] eb);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_rd_we = we;
    drv_ea       = ea;
    drv_eb       = eb;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 12'h0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic setWb(input logic en, input logic [3:0] wr, input logic [15:0] data);
    wb_en   = en;
    wb_wr   = wr;
    wb_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected operands are queued at accept and compared when execute takes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        handshakes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got output op=%h, expected none", bus.out_op);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out_op", 32'(bus.out_op), 32'(mon_e.op));
          checkOutput("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
          checkOutput("out_rd_we", 32'(bus.out_rd_we), 32'(mon_e.we));
          checkOutput("out_a", 32'(bus.out_a), 32'(mon_e.a));
          checkOutput("out_b", 32'(bus.out_b), 32'(mon_e.b));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{op: bus.in_op, rd: bus.in_rd, we: bus.in_rd_we, a: drv_ea, b: drv_eb});
    end
  end

  int hs0;
  int ks [3];

  initial begin
    vecs[0] = '{12'h001, 4'd3,  4'd0,  4'd0, 1'b0, 16'h1234, 16'h0000};
    vecs[1] = '{12'h002, 4'd1,  4'd2,  4'd0, 1'b0, 16'h1111, 16'h2222};
    vecs[2] = '{12'h003, 4'd4,  4'd6,  4'd0, 1'b0, 16'h4444, 16'h6666};
    vecs[3] = '{12'h004, 4'd0,  4'd15, 4'd0, 1'b1, 16'h0000, 16'hFFFF};
    vecs[4] = '{12'h005, 4'd10, 4'd10, 4'd0, 1'b0, 16'hAAAA, 16'hAAAA};
    vecs[5] = '{12'h006, 4'd8,  4'd1,  4'd0, 1'b0, 16'h8888, 16'h1111};
    ks[0] = 4; ks[1] = 6; ks[2] = 8;

    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_out_a", 32'(bus.out_a), 32'd0);
    checkOutput("rst_out_b", 32'(bus.out_b), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Back-to-back independent instructions, including rd=0 with we=1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we,
                    vecs[i].ea, vecs[i].eb);
      @(negedge clk);
      checkOutput("vec_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("vec_rf_rd_2", 32'(rf_rd_2), 32'(vecs[i].rs2));
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    checkOutput("vec_pending", 32'(pending), 32'd0);
    tick();

    // RAW on r5 resolved by a writeback of 0xBEEF.
    applyStimulus(1'b1, 12'h010, 4'd1, 4'd0, 4'd5, 1'b1, 16'h1111, 16'h0000);
    tick();
    applyStimulus(1'b1, 12'h011, 4'd5, 4'd2, 4'd0, 1'b0, 16'hBEEF, 16'h2222);
    @(negedge clk);
    checkOutput("raw_stall", 32'(bus.in_ready), 32'd0);
    checkOutput("raw_pending", 32'(pending), 32'h0020);
    tick();
    setWb(1'b1, 4'd5, 16'hBEEF);
    @(negedge clk);
`ifdef OPFETCH_FWD_EN
    checkOutput("raw_fwd_ready", 32'(bus.in_ready), 32'd1);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
    idle();
`else
    checkOutput("raw_nofwd_stall", 32'(bus.in_ready), 32'd0);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
    @(negedge clk);
    checkOutput("raw_nofwd_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
`endif
    tick();
    @(negedge clk);
    checkOutput("raw_pending_clr", 32'(pending), 32'd0);
    tick();

    // Backpressure: operand held while the read address keeps moving.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 12'h020, 4'd3, 4'd0, 4'd0, 1'b0, 16'h1234, 16'h0000);
    tick();
    hs0 = handshakes;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 12'h0, 4'(ks[k]), 4'(ks[k]), 4'd0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_out_a", 32'(bus.out_a), 32'h1234);
      checkOutput("bp_rf_rd_1", 32'(rf_rd_1), 32'(ks[k]));
      tick();
    end
    bus.out_ready = 1'b1;
    idle();
    tick();
    tick();
    @(negedge clk);
    checkOutput("bp_out_valid_drop", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_handshakes", 32'(handshakes - hs0), 32'd1);
    tick();

    // WAW on r7; the accept and the clearing writeback may share an edge.
    applyStimulus(1'b1, 12'h030, 4'd0, 4'd0, 4'd7, 1'b1, 16'h0000, 16'h0000);
    tick();
    applyStimulus(1'b1, 12'h031, 4'd1, 4'd0, 4'd7, 1'b1, 16'h1111, 16'h0000);
    @(negedge clk);
    checkOutput("waw_stall", 32'(bus.in_ready), 32'd0);
    checkOutput("waw_pending", 32'(pending), 32'h0080);
    tick();
    setWb(1'b1, 4'd7, 16'h7777);
    @(negedge clk);
`ifdef OPFETCH_FWD_EN
    checkOutput("waw_fwd_ready", 32'(bus.in_ready), 32'd1);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
`else
    checkOutput("waw_nofwd_stall", 32'(bus.in_ready), 32'd0);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
    @(negedge clk);
    checkOutput("waw_nofwd_ready", 32'(bus.in_ready), 32'd1);
    tick();
`endif
    idle();
    @(negedge clk);
    checkOutput("waw_set_wins", 32'(pending), 32'h0080);
    tick();
    setWb(1'b1, 4'd7, 16'h7777);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
    @(negedge clk);
    checkOutput("waw_pending_clr", 32'(pending), 32'd0);
    tick();

    // Writeback to a register that is not pending: no stall, no scoreboard change.
    applyStimulus(1'b1, 12'h050, 4'd2, 4'd4, 4'd0, 1'b0, 16'h2222, 16'h4444);
    setWb(1'b1, 4'd9, 16'h9999);
    @(negedge clk);
    checkOutput("wb_nopend_ready", 32'(bus.in_ready), 32'd1);
    tick();
    setWb(1'b0, 4'd0, 16'h0);
    idle();
    @(negedge clk);
    checkOutput("wb_nopend_pending", 32'(pending), 32'd0);
    tick();

    // Asynchronous reset while stalled with a held output and a pending write.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 12'h040, 4'd0, 4'd0, 4'd5, 1'b1, 16'h0000, 16'h0000);
    tick();
    applyStimulus(1'b1, 12'h041, 4'd5, 4'd0, 4'd0, 1'b0, 16'h5555, 16'h0000);
    @(negedge clk);
    checkOutput("mid_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mid_pending", 32'(pending), 32'h0020);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("areset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("areset_pending", 32'(pending), 32'd0);
    checkOutput("areset_out_op", 32'(bus.out_op), 32'd0);
    checkOutput("areset_out_a", 32'(bus.out_a), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("areset_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
